// File: rtl/fpc_arb2.sv
// ============================================================================
//  Module   : fpc_arb2
//  Brief    : Two-requester round-robin front end for one shared bfloat16 FP
//             unit, with per-requester response buffers and a result timeout.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fpc_arb2 (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req0_mode,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_data,
  input  logic        rsp0_ready,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic        req1_mode,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_data,
  input  logic        rsp1_ready,

  output logic        fpc_in_valid,
  output logic [15:0] fpc_in_a,
  output logic [15:0] fpc_in_b,
  output logic        fpc_mode,
  input  logic        fpc_out_valid,
  input  logic [15:0] fpc_out,

  output logic        busy,
  output logic        err
);

  localparam logic [15:0] C_QNAN     = 16'h7FC0;
  localparam logic [3:0]  C_TCNT_MAX = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_rr;
  logic [3:0]  r_tcnt;
  logic        r_err;
  logic        r_rsp0_valid;
  logic        r_rsp1_valid;
  logic [15:0] r_rsp0_data;
  logic [15:0] r_rsp1_data;
  logic [15:0] r_op_a;
  logic [15:0] r_op_b;
  logic        r_op_mode;
  logic        r_owner;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_gnt_any;
  logic        w_gnt_id;
  logic        w_done;
  logic        w_wr0;
  logic        w_wr1;
  logic [15:0] w_res;

  // A requester whose result is still unread cannot start another op.
  assign w_elig0   = req0_valid & ~r_rsp0_valid;
  assign w_elig1   = req1_valid & ~r_rsp1_valid;
  assign w_gnt_any = (r_state == S_IDLE) & (w_elig0 | w_elig1);
  assign w_gnt_id  = (w_elig0 & w_elig1) ? r_rr : w_elig1;

  assign w_done = (r_state == S_WAIT) & (fpc_out_valid | (r_tcnt == C_TCNT_MAX));
  assign w_res  = fpc_out_valid ? fpc_out : C_QNAN;
  assign w_wr0  = w_done & ~r_owner;
  assign w_wr1  = w_done &  r_owner;

  // Handshake is gated by rst_n so nothing is accepted while reset is held.
  assign req0_ready = rst_n & w_gnt_any & ~w_gnt_id;
  assign req1_ready = rst_n & w_gnt_any &  w_gnt_id;

  assign fpc_in_valid = (r_state == S_ISSUE);
  assign fpc_in_a     = r_op_a;
  assign fpc_in_b     = r_op_b;
  assign fpc_mode     = r_op_mode;
  assign busy         = (r_state != S_IDLE);
  assign err          = r_err;
  assign rsp0_valid   = r_rsp0_valid;
  assign rsp1_valid   = r_rsp1_valid;
  assign rsp0_data    = r_rsp0_data;
  assign rsp1_data    = r_rsp1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rr         <= 1'b0;
      r_tcnt       <= 4'd0;
      r_err        <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_data  <= 16'd0;
      r_rsp1_data  <= 16'd0;
      r_op_a       <= 16'd0;
      r_op_b       <= 16'd0;
      r_op_mode    <= 1'b0;
      r_owner      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_any) begin
            r_op_a    <= w_gnt_id ? req1_a    : req0_a;
            r_op_b    <= w_gnt_id ? req1_b    : req0_b;
            r_op_mode <= w_gnt_id ? req1_mode : req0_mode;
            r_owner   <= w_gnt_id;
            r_rr      <= ~w_gnt_id;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tcnt  <= 4'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (fpc_out_valid) begin
            r_state <= S_IDLE;
          end else if (r_tcnt == C_TCNT_MAX) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A write never targets a buffer that is being popped: the owner's
      // buffer was empty at grant and only this path fills it.
      if (w_wr0) begin
        r_rsp0_valid <= 1'b1;
        r_rsp0_data  <= w_res;
      end else if (rsp0_ready) begin
        r_rsp0_valid <= 1'b0;
      end

      if (w_wr1) begin
        r_rsp1_valid <= 1'b1;
        r_rsp1_data  <= w_res;
      end else if (rsp1_ready) begin
        r_rsp1_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpc_arb2.sv
// ============================================================================
//  Module   : tb_fpc_arb2
//  Brief    : Directed self-checking bench for fpc_arb2 with a 2-cycle FP model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fpc_arb2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_mode, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, req1_mode, rsp1_valid, rsp1_ready;
  logic [15:0] req0_a, req0_b, rsp0_data, req1_a, req1_b, rsp1_data;
  logic        fpc_in_valid, fpc_mode, fpc_out_valid, busy, err;
  logic [15:0] fpc_in_a, fpc_in_b, fpc_out;

  int checks   = 0;
  int failures = 0;

  fpc_arb2 dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_mode(req0_mode), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_mode(req1_mode), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .fpc_in_valid(fpc_in_valid), .fpc_in_a(fpc_in_a), .fpc_in_b(fpc_in_b), .fpc_mode(fpc_mode),
    .fpc_out_valid(fpc_out_valid), .fpc_out(fpc_out),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Hand-computed bfloat16 results for the operand pairs used below.
  function automatic logic [15:0] fp_ref(input logic [15:0] a, input logic [15:0] b, input logic m);
    case ({a, b, m})
      {16'h3F80, 16'h4000, 1'b0}: return 16'h4040;
      {16'h4000, 16'h4040, 1'b1}: return 16'h40C0;
      {16'h3F80, 16'h3F80, 1'b0}: return 16'h4000;
      {16'h4000, 16'h4000, 1'b1}: return 16'h4080;
      {16'h4040, 16'h3F80, 1'b0}: return 16'h4080;
      default:                    return 16'h0000;
    endcase
  endfunction

  // FP unit model: result pulse two cycles after the in_valid cycle.
  logic        s1 = 1'b0, s2 = 1'b0, fpu_en = 1'b1;
  logic [15:0] res1 = 16'd0, res2 = 16'd0;
  always @(posedge clk) begin
    s1   <= fpc_in_valid & fpu_en;
    res1 <= fp_ref(fpc_in_a, fpc_in_b, fpc_mode);
    s2   <= s1;
    res2 <= res1;
  end
  assign fpc_out_valid = s2;
  assign fpc_out       = res2;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [15:0] a, input logic [15:0] b, input logic m);
    req0_valid = v; req0_a = a; req0_b = b; req0_mode = m;
  endtask

  task automatic set_req1(input logic v, input logic [15:0] a, input logic [15:0] b, input logic m);
    req1_valid = v; req1_a = a; req1_b = b; req1_mode = m;
  endtask

  initial begin
    rst_n = 1'b0;
    set_req0(1'b1, 16'h3F80, 16'h4000, 1'b0);
    set_req1(1'b0, 16'h0, 16'h0, 1'b0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    cyc(); cyc();
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_rsp0_valid", {15'd0, rsp0_valid}, 16'd0);
    chk("rst_rsp1_valid", {15'd0, rsp1_valid}, 16'd0);
    chk("rst_rsp0_data", rsp0_data, 16'd0);
    chk("rst_fpc_in_valid", {15'd0, fpc_in_valid}, 16'd0);
    chk("rst_fpc_in_a", fpc_in_a, 16'd0);
    chk("rst_req0_ready", {15'd0, req0_ready}, 16'd0);

    // Single op, granted in the first cycle after reset release
    rst_n = 1'b1; #1;
    chk("s_ready0_k", {15'd0, req0_ready}, 16'd1);
    chk("s_ready1_k", {15'd0, req1_ready}, 16'd0);
    cyc(); req0_valid = 1'b0; #1;
    chk("s_in_valid_k1", {15'd0, fpc_in_valid}, 16'd1);
    chk("s_in_a_k1", fpc_in_a, 16'h3F80);
    chk("s_in_b_k1", fpc_in_b, 16'h4000);
    chk("s_mode_k1", {15'd0, fpc_mode}, 16'd0);
    chk("s_ready0_k1", {15'd0, req0_ready}, 16'd0);
    cyc();
    chk("s_in_valid_k2", {15'd0, fpc_in_valid}, 16'd0);
    chk("s_busy_k2", {15'd0, busy}, 16'd1);
    chk("s_in_a_hold_k2", fpc_in_a, 16'h3F80);
    cyc();
    chk("s_rsp0_valid_k3", {15'd0, rsp0_valid}, 16'd0);
    cyc();
    chk("s_rsp0_valid_k4", {15'd0, rsp0_valid}, 16'd1);
    chk("s_rsp0_data_k4", rsp0_data, 16'h4040);
    chk("s_busy_k4", {15'd0, busy}, 16'd0);
    rsp0_ready = 1'b1;
    cyc(); rsp0_ready = 1'b0; #1;
    chk("s_pop0", {15'd0, rsp0_valid}, 16'd0);

    // Contention from reset: req0 first, req1 at k+4, then rr back to 0
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    set_req0(1'b1, 16'h3F80, 16'h4000, 1'b0);
    set_req1(1'b1, 16'h4000, 16'h4040, 1'b1);
    #1;
    chk("c_ready0_k", {15'd0, req0_ready}, 16'd1);
    chk("c_ready1_k", {15'd0, req1_ready}, 16'd0);
    cyc(); req0_valid = 1'b0; #1;
    chk("c_ready1_k1", {15'd0, req1_ready}, 16'd0);
    cyc(); cyc(); cyc();
    chk("c_rsp0_valid_k4", {15'd0, rsp0_valid}, 16'd1);
    chk("c_rsp0_data_k4", rsp0_data, 16'h4040);
    chk("c_ready1_k4", {15'd0, req1_ready}, 16'd1);
    cyc(); req1_valid = 1'b0; #1;
    chk("c_in_a_k5", fpc_in_a, 16'h4000);
    chk("c_in_b_k5", fpc_in_b, 16'h4040);
    chk("c_mode_k5", {15'd0, fpc_mode}, 16'd1);
    cyc(); cyc(); cyc();
    chk("c_rsp1_valid_k8", {15'd0, rsp1_valid}, 16'd1);
    chk("c_rsp1_data_k8", rsp1_data, 16'h40C0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    cyc();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req0(1'b1, 16'h3F80, 16'h3F80, 1'b0);
    set_req1(1'b1, 16'h4000, 16'h4000, 1'b1);
    #1;
    chk("c_rr_ready0", {15'd0, req0_ready}, 16'd1);
    chk("c_rr_ready1", {15'd0, req1_ready}, 16'd0);
    cyc(); req0_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("c_rsp0_data_2", rsp0_data, 16'h4000);
    chk("c_ready1_2", {15'd0, req1_ready}, 16'd1);

    // Backpressure: rsp0 full blocks req0's second op; req1 proceeds
    set_req0(1'b1, 16'h4040, 16'h3F80, 1'b0); #1;
    chk("b_ready0_blocked", {15'd0, req0_ready}, 16'd0);
    chk("b_ready1_still", {15'd0, req1_ready}, 16'd1);
    cyc(); req1_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("b_rsp1_valid", {15'd0, rsp1_valid}, 16'd1);
    chk("b_rsp1_data", rsp1_data, 16'h4080);
    chk("b_ready0_idle_blocked", {15'd0, req0_ready}, 16'd0);
    rsp0_ready = 1'b1;
    cyc(); rsp0_ready = 1'b0; #1;
    chk("b_rsp0_popped", {15'd0, rsp0_valid}, 16'd0);
    chk("b_ready0_after_pop", {15'd0, req0_ready}, 16'd1);

    // Pop of rsp1 in the same cycle rsp0 is written
    cyc(); req0_valid = 1'b0;
    cyc(); cyc(); rsp1_ready = 1'b1; #1;
    chk("p_fpc_out_valid", {15'd0, fpc_out_valid}, 16'd1);
    cyc(); rsp1_ready = 1'b0; #1;
    chk("p_rsp0_valid", {15'd0, rsp0_valid}, 16'd1);
    chk("p_rsp0_data", rsp0_data, 16'h4080);
    chk("p_rsp1_valid", {15'd0, rsp1_valid}, 16'd0);

    // Timeout: FP unit never answers
    fpu_en = 1'b0;
    rsp0_ready = 1'b1;
    cyc();
    rsp0_ready = 1'b0;
    set_req0(1'b1, 16'h3F80, 16'h4000, 1'b0); #1;
    chk("t_ready0", {15'd0, req0_ready}, 16'd1);
    cyc(); req0_valid = 1'b0;
    for (int i = 0; i < 16; i++) cyc();
    chk("t_rsp0_valid_early", {15'd0, rsp0_valid}, 16'd0);
    chk("t_busy_last_wait", {15'd0, busy}, 16'd1);
    chk("t_err_early", {15'd0, err}, 16'd0);
    cyc();
    chk("t_rsp0_valid", {15'd0, rsp0_valid}, 16'd1);
    chk("t_rsp0_data", rsp0_data, 16'h7FC0);
    chk("t_err", {15'd0, err}, 16'd1);
    chk("t_busy", {15'd0, busy}, 16'd0);
    fpu_en = 1'b1;
    set_req1(1'b1, 16'h3F80, 16'h4000, 1'b0); #1;
    chk("t_next_ready1", {15'd0, req1_ready}, 16'd1);
    cyc(); req1_valid = 1'b0;
    cyc(); cyc(); cyc();
    chk("t_next_rsp1_valid", {15'd0, rsp1_valid}, 16'd1);
    chk("t_next_rsp1_data", rsp1_data, 16'h4040);
    chk("t_err_sticky", {15'd0, err}, 16'd1);

    // Reset asserted in WAIT; late FP result must be ignored
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    cyc();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req0(1'b1, 16'h4040, 16'h3F80, 1'b0); #1;
    chk("r_ready0", {15'd0, req0_ready}, 16'd1);
    cyc(); req0_valid = 1'b0;
    cyc();
    rst_n = 1'b0; req0_valid = 1'b1; #1;
    chk("r_busy", {15'd0, busy}, 16'd0);
    chk("r_in_valid", {15'd0, fpc_in_valid}, 16'd0);
    chk("r_ready0_in_rst", {15'd0, req0_ready}, 16'd0);
    chk("r_err_cleared", {15'd0, err}, 16'd0);
    chk("r_in_a_cleared", fpc_in_a, 16'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    cyc();
    chk("r_late_out_valid", {15'd0, fpc_out_valid}, 16'd1);
    chk("r_busy_late", {15'd0, busy}, 16'd0);
    cyc();
    chk("r_rsp0_valid", {15'd0, rsp0_valid}, 16'd0);
    chk("r_rsp1_valid", {15'd0, rsp1_valid}, 16'd0);
    chk("r_rsp0_data", rsp0_data, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
